// File: rtl/apb_master_mux.sv
// apb_master_mux
// Valid/ready command channel to a shared APB bus with NS slaves.
// Registered SETUP/ACCESS phases, per-slave PSEL decode, decode-error and
// ACCESS timeout handling, and a held (back-pressurable) response channel.
module apb_master_mux #(
  parameter int DW     = 32,
  parameter int AW     = 16,
  parameter int NS     = 4,
  parameter int SLV_AW = 12,
  parameter int TMO    = 256
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic                 i_cmd_write,
  input  logic [AW-1:0]        i_cmd_addr,
  input  logic [DW-1:0]        i_cmd_wdata,
  input  logic [DW/8-1:0]      i_cmd_strb,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [DW-1:0]        o_rsp_rdata,
  output logic [1:0]           o_rsp_code,
  output logic [AW-1:0]        o_paddr,
  output logic                 o_pwrite,
  output logic [NS-1:0]        o_psel,
  output logic                 o_penable,
  output logic [DW-1:0]        o_pwdata,
  output logic [DW/8-1:0]      o_pstrb,
  input  logic [NS*DW-1:0]     i_prdata,
  input  logic [NS-1:0]        i_pready,
  input  logic [NS-1:0]        i_pslverr
);

  localparam int SW   = DW / 8;
  localparam int IW   = (NS > 1) ? $clog2(NS) : 1;
  localparam int HI   = SLV_AW + IW;
  localparam int CW   = (TMO > 1) ? $clog2(TMO) : 1;
  localparam int TLIM = (TMO > 0) ? TMO - 1 : 0;

  localparam logic [CW-1:0] TLIM_C  = CW'(TLIM);
  localparam logic [NS-1:0] SEL_ONE = NS'(1);

  localparam logic [1:0] RSP_OKAY    = 2'b00;
  localparam logic [1:0] RSP_SLVERR  = 2'b01;
  localparam logic [1:0] RSP_DECERR  = 2'b10;
  localparam logic [1:0] RSP_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx_q;
  logic [CW-1:0]   tmo_cnt;

  logic [IW-1:0]   cmd_idx;
  logic            cmd_hi;
  logic            idx_bad;
  logic            cmd_decerr;

  logic            sel_ready;
  logic            sel_err;
  logic [DW-1:0]   sel_rdata;

  assign o_cmd_ready = (state == S_IDLE) && !i_reset;

  // Address decode of the incoming command: slave index and out-of-map bits
  always_comb begin
    cmd_idx    = i_cmd_addr[SLV_AW +: IW];
    cmd_hi     = |(i_cmd_addr >> HI);
    cmd_decerr = cmd_hi || idx_bad;
  end

  // Index range check only exists when NS does not fill the index field
  if (NS < (1 << IW)) begin : g_partial_map
    always_comb idx_bad = (cmd_idx > IW'(NS - 1));
  end else begin : g_full_map
    always_comb idx_bad = 1'b0;
  end

  // Observe only the selected slave's ready/error/read data
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int unsigned k = 0; k < NS; k++) begin
      if (idx_q == IW'(k)) begin
        sel_ready = i_pready[k];
        sel_err   = i_pslverr[k];
        sel_rdata = i_prdata[k*DW +: DW];
      end
    end
  end

  // Transfer FSM; every APB and response output is registered here
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= S_IDLE;
      idx_q       <= '0;
      tmo_cnt     <= '0;
      o_paddr     <= '0;
      o_pwrite    <= 1'b0;
      o_psel      <= '0;
      o_penable   <= 1'b0;
      o_pwdata    <= '0;
      o_pstrb     <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_code  <= RSP_OKAY;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            if (cmd_decerr) begin
              o_rsp_valid <= 1'b1;
              o_rsp_rdata <= '0;
              o_rsp_code  <= RSP_DECERR;
              state       <= S_RESP;
            end else begin
              idx_q     <= cmd_idx;
              tmo_cnt   <= '0;
              o_psel    <= SEL_ONE << cmd_idx;
              o_penable <= 1'b0;
              o_paddr   <= i_cmd_addr;
              o_pwrite  <= i_cmd_write;
              o_pwdata  <= i_cmd_write ? i_cmd_wdata : '0;
              o_pstrb   <= i_cmd_write ? i_cmd_strb : SW'(0);
              state     <= S_SETUP;
            end
          end
        end

        S_SETUP: begin
          o_penable <= 1'b1;
          state     <= S_ACCESS;
        end

        S_ACCESS: begin
          // Ready is tested before the timeout so it wins a same-cycle tie
          if (sel_ready) begin
            o_psel      <= '0;
            o_penable   <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= o_pwrite ? '0 : sel_rdata;
            o_rsp_code  <= sel_err ? RSP_SLVERR : RSP_OKAY;
            state       <= S_RESP;
          end else if ((TMO != 0) && (tmo_cnt == TLIM_C)) begin
            o_psel      <= '0;
            o_penable   <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= '0;
            o_rsp_code  <= RSP_TIMEOUT;
            state       <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_mux.sv
// tb_apb_master_mux
// Directed bench: stimulus pushes expected responses into a scoreboard queue,
// a monitor pops and compares on every response handshake. APB-side timing
// is checked inline by the stimulus.
module tb_apb_master_mux;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int NS = 4;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              i_reset;
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic              i_cmd_write;
  logic [AW-1:0]     i_cmd_addr;
  logic [DW-1:0]     i_cmd_wdata;
  logic [SW-1:0]     i_cmd_strb;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [DW-1:0]     o_rsp_rdata;
  logic [1:0]        o_rsp_code;
  logic [AW-1:0]     o_paddr;
  logic              o_pwrite;
  logic [NS-1:0]     o_psel;
  logic              o_penable;
  logic [DW-1:0]     o_pwdata;
  logic [SW-1:0]     o_pstrb;
  logic [NS*DW-1:0]  i_prdata;
  logic [NS-1:0]     i_pready;
  logic [NS-1:0]     i_pslverr;

  apb_master_mux #(
    .DW(DW), .AW(AW), .NS(NS), .SLV_AW(12), .TMO(8)
  ) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_write(i_cmd_write), .i_cmd_addr(i_cmd_addr),
    .i_cmd_wdata(i_cmd_wdata), .i_cmd_strb(i_cmd_strb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_code(o_rsp_code),
    .o_paddr(o_paddr), .o_pwrite(o_pwrite), .o_psel(o_psel),
    .o_penable(o_penable), .o_pwdata(o_pwdata), .o_pstrb(o_pstrb),
    .i_prdata(i_prdata), .i_pready(i_pready), .i_pslverr(i_pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rdata;
    logic [1:0]    code;
  } rsp_t;

  rsp_t sb[$];
  rsp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller 1 time unit after the handshake edge (SETUP cycle)
  task automatic issue(input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [SW-1:0] st);
    int n;
    n = 0;
    while (!o_cmd_ready && n < 50) begin
      step();
      n++;
    end
    chk("cmd_ready_wait", o_cmd_ready, 1);
    i_cmd_valid = 1'b1;
    i_cmd_write = wr;
    i_cmd_addr  = addr;
    i_cmd_wdata = wd;
    i_cmd_strb  = st;
    step();
    i_cmd_valid = 1'b0;
  endtask

  // Response monitor and bus invariants
  always @(negedge clk) begin
    if (!i_reset) begin
      chk("psel_onehot0", $onehot0(o_psel), 1);
      chk("penable_without_psel", o_penable && (o_psel == '0), 0);
      if (o_rsp_valid && i_rsp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_rdata", o_rsp_rdata, mon_e.rdata);
          chk("rsp_code", o_rsp_code, mon_e.code);
        end
      end
    end
  end

  // Slave 2 read with three wait states; stray ready/err on other slaves
  task automatic read_wait(input logic err);
    i_prdata  = {32'hBAD3BAD3, 32'h12345678, 32'hBAD1BAD1, 32'hBAD0BAD0};
    i_pslverr = err ? 4'b0100 : 4'b1011;
    i_pready  = 4'b1011;
    sb.push_back('{32'h12345678, err ? 2'b01 : 2'b00});
    issue(1'b0, 16'h2004, 32'hFFFFFFFF, 4'hF);
    chk("rd_setup_psel", o_psel, 4'b0100);
    chk("rd_setup_penable", o_penable, 0);
    chk("rd_pwrite", o_pwrite, 0);
    chk("rd_pstrb", o_pstrb, 0);
    chk("rd_pwdata", o_pwdata, 0);
    chk("rd_paddr", o_paddr, 16'h2004);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rd_wait_penable", o_penable, 1);
      chk("rd_wait_psel", o_psel, 4'b0100);
      chk("rd_wait_paddr", o_paddr, 16'h2004);
      chk("rd_wait_rsp_valid", o_rsp_valid, 0);
    end
    step();
    chk("rd_4th_penable", o_penable, 1);
    i_pready = 4'b0100;
    step();
    chk("rd_done_psel", o_psel, 0);
    chk("rd_done_penable", o_penable, 0);
    chk("rd_done_rsp_valid", o_rsp_valid, 1);
    step();
    i_pready  = '0;
    i_pslverr = '0;
  endtask

  // Slave 0 read; optionally ready in the 8th ACCESS cycle
  task automatic tmo_run(input logic ready_at_8);
    int pen_cnt;
    int n;
    i_prdata = {32'h0, 32'h0, 32'h0, 32'hA5A50F0F};
    i_pready = '0;
    sb.push_back('{ready_at_8 ? 32'hA5A50F0F : 32'h0, ready_at_8 ? 2'b00 : 2'b11});
    issue(1'b0, 16'h0000, 32'h0, 4'h0);
    pen_cnt = 0;
    n = 0;
    while (!o_rsp_valid && n < 20) begin
      step();
      n++;
      if (o_penable) pen_cnt++;
      if (ready_at_8 && o_penable && pen_cnt == 8) i_pready = 4'b0001;
    end
    chk("tmo_penable_cycles", pen_cnt, 8);
    chk("tmo_rsp_valid", o_rsp_valid, 1);
    chk("tmo_psel_dropped", o_psel, 0);
    step();
    i_pready = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset     = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_write = 1'b0;
    i_cmd_addr  = '0;
    i_cmd_wdata = '0;
    i_cmd_strb  = '0;
    i_rsp_ready = 1'b1;
    i_prdata    = '0;
    i_pready    = '0;
    i_pslverr   = '0;

    // Reset state
    repeat (3) step();
    chk("rst_psel", o_psel, 0);
    chk("rst_penable", o_penable, 0);
    chk("rst_paddr", o_paddr, 0);
    chk("rst_pwrite", o_pwrite, 0);
    chk("rst_pwdata", o_pwdata, 0);
    chk("rst_pstrb", o_pstrb, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_rsp_rdata", o_rsp_rdata, 0);
    chk("rst_rsp_code", o_rsp_code, 0);
    chk("rst_cmd_ready", o_cmd_ready, 0);
    i_reset = 1'b0;
    #1;
    chk("post_rst_cmd_ready", o_cmd_ready, 1);
    step();

    // Zero-wait write to slave 1
    i_pready = 4'b0010;
    sb.push_back('{32'h0, 2'b00});
    issue(1'b1, 16'h1010, 32'hDEADBEEF, 4'hF);
    chk("wr_setup_psel", o_psel, 4'b0010);
    chk("wr_setup_penable", o_penable, 0);
    chk("wr_paddr", o_paddr, 16'h1010);
    chk("wr_pwrite", o_pwrite, 1);
    chk("wr_pwdata", o_pwdata, 32'hDEADBEEF);
    chk("wr_pstrb", o_pstrb, 4'hF);
    chk("wr_cmd_ready_busy", o_cmd_ready, 0);
    step();
    chk("wr_access_psel", o_psel, 4'b0010);
    chk("wr_access_penable", o_penable, 1);
    chk("wr_access_pwdata", o_pwdata, 32'hDEADBEEF);
    step();
    chk("wr_done_psel", o_psel, 0);
    chk("wr_done_penable", o_penable, 0);
    chk("wr_rsp_valid_cycle3", o_rsp_valid, 1);
    step();
    i_pready = '0;
    chk("wr_back_idle_rsp_valid", o_rsp_valid, 0);
    chk("wr_back_idle_cmd_ready", o_cmd_ready, 1);

    // Wait-state reads, OKAY then SLVERR
    read_wait(1'b0);
    read_wait(1'b1);

    // Decode errors
    begin
      logic [AW-1:0] bad_addr [2];
      bad_addr[0] = 16'h4000;
      bad_addr[1] = 16'h8000;
      i_pready = 4'b1111;
      for (int i = 0; i < 2; i++) begin
        sb.push_back('{32'h0, 2'b10});
        issue(1'b1, bad_addr[i], 32'h11111111, 4'hF);
        chk("dec_psel", o_psel, 0);
        chk("dec_penable", o_penable, 0);
        chk("dec_rsp_valid", o_rsp_valid, 1);
        step();
        chk("dec_cmd_ready", o_cmd_ready, 1);
        chk("dec_psel_after", o_psel, 0);
      end
      i_pready = '0;
    end

    // Timeout, then ready exactly at the timeout limit
    tmo_run(1'b0);
    tmo_run(1'b1);

    // Response back-pressure with a pending decode-error command
    begin
      int n;
      i_rsp_ready = 1'b0;
      i_pready    = 4'b1000;
      sb.push_back('{32'h0, 2'b00});
      issue(1'b1, 16'h3008, 32'h0BADF00D, 4'h3);
      chk("bp_pstrb", o_pstrb, 4'h3);
      n = 0;
      while (!o_rsp_valid && n < 10) begin
        step();
        n++;
      end
      i_cmd_valid = 1'b1;
      i_cmd_write = 1'b1;
      i_cmd_addr  = 16'h8000;
      sb.push_back('{32'h0, 2'b10});
      for (int i = 0; i < 5; i++) begin
        chk("bp_rsp_valid", o_rsp_valid, 1);
        chk("bp_rsp_code", o_rsp_code, 2'b00);
        chk("bp_rsp_rdata", o_rsp_rdata, 0);
        chk("bp_cmd_ready", o_cmd_ready, 0);
        chk("bp_psel", o_psel, 0);
        chk("bp_penable", o_penable, 0);
        step();
      end
      i_rsp_ready = 1'b1;
      step();
      chk("bp_idle_cmd_ready", o_cmd_ready, 1);
      chk("bp_idle_rsp_valid", o_rsp_valid, 0);
      step();
      i_cmd_valid = 1'b0;
      chk("bp_next_rsp_valid", o_rsp_valid, 1);
      chk("bp_next_rsp_code", o_rsp_code, 2'b10);
      step();
      i_pready = '0;
    end

    // Reset during ACCESS, with the selected slave ready at the same edge
    i_pready = '0;
    issue(1'b0, 16'h1000, 32'h0, 4'h0);
    step();
    chk("mid_rst_access_penable", o_penable, 1);
    i_reset  = 1'b1;
    i_pready = 4'b0010;
    step();
    chk("mid_rst_psel", o_psel, 0);
    chk("mid_rst_penable", o_penable, 0);
    chk("mid_rst_rsp_valid", o_rsp_valid, 0);
    chk("mid_rst_cmd_ready", o_cmd_ready, 0);
    i_reset  = 1'b0;
    i_pready = '0;
    #1;
    chk("mid_rst_release_cmd_ready", o_cmd_ready, 1);
    step();
    chk("mid_rst_no_rsp", o_rsp_valid, 0);

    // Reset discards a pending response
    i_rsp_ready = 1'b0;
    issue(1'b0, 16'h4000, 32'h0, 4'h0);
    chk("pend_rsp_valid", o_rsp_valid, 1);
    i_reset = 1'b1;
    step();
    chk("pend_rst_rsp_valid", o_rsp_valid, 0);
    i_reset     = 1'b0;
    i_rsp_ready = 1'b1;
    step();
    chk("pend_after_rsp_valid", o_rsp_valid, 0);
    chk("pend_after_cmd_ready", o_cmd_ready, 1);

    repeat (3) step();
    chk("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
